operand_stack: RTL and testbench
================================

Name: operand_stack

Overview:
- Typed value stack behind the wasm CPU execute stage; every local.get, const and arithmetic op pushes/pops through it.
- Holds 64-bit values, each tagged with a 2-bit wasm type (i32/i64/f32/f64 codes from cpu.vh).
- Its top-of-stack view drives the CPU's result, result_type and result_empty outputs.
- Detects overflow and underflow and raises a sticky trap code to the CPU trap output.

Parameters:
- DEPTH_LOG, 4, log2 of entry count (16 entries).
- WIDTH, 64, value width in bits.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- push  in  1  write push_data/push_type as the new top.
- pop  in  1  remove one entry.
- pop2  in  1  remove two entries (binary ops); has priority over pop.
- push_data  in  WIDTH  value to push.
- push_type  in  2  wasm type code of push_data.
- top_data  out  WIDTH  entry at depth-1.
- top_type  out  2  type of top entry.
- second_data  out  WIDTH  entry at depth-2.
- second_type  out  2  type of second entry.
- depth  out  DEPTH_LOG+1  current entry count.
- empty  out  1  depth==0.
- full  out  1  depth==2^DEPTH_LOG.
- trap  out  4  sticky stack trap code.

Behaviour:
- Reset (reset low, asynchronous): depth=0, trap=0, empty=1, full=0. top/second outputs read 0 with type 0. Storage contents are don't-care.
- All state updates happen on the rising clk edge. top/second/depth/empty/full are combinational from registered state, so they reflect an operation on the cycle after its edge. Latency is 1 cycle; there is no handshake and every request is accepted or trapped in its cycle.
- When an entry index is invalid (depth<1 for top, depth<2 for second), that output reads data 0, type 0.
- Operation decode per cycle, with n = 2 if pop2, else 1 if pop, else 0:
  - push only: mem[depth] <= push; depth+1.
  - pop only: depth-1.
  - pop2 only: depth-2.
  - push+pop: replace top, mem[depth-1] <= push; depth unchanged.
  - push+pop2: mem[depth-2] <= push; depth-1.
  - None asserted: hold.
- Underflow: n > depth (pop on empty, pop2 with depth<2, including with push). Result: trap <= 4'd9, no write, depth unchanged.
- Overflow: push with n==0 while full. Result: trap <= 4'd8, no write. push+pop while full is legal (replace).
- trap is sticky. Once nonzero, all later push/pop/pop2 are ignored and the state is frozen until reset. Only the first fault is recorded.
- Reset asserted mid-operation wins immediately, regardless of the clock.
- Type tags are stored verbatim. No type checking is done here; that belongs to the decoder.
- Depth arithmetic is unsigned DEPTH_LOG+1 bits. Guards mean it never wraps.

Decomposition:
- cpu.vh (shared header) holds:
  - the existing type codes `i32/`i64/`f32/`f64;
  - new trap codes `STACK_OVERFLOW=4'd8 and `STACK_UNDERFLOW=4'd9;
  - `TRAP_NONE=4'd0.
- One natural sub-module: stack_mem, a 2^DEPTH_LOG x (WIDTH+2) register file with one write port and two combinational read ports (top, second).
- operand_stack keeps the pointer, decode and trap FSM. The FSM has two states:
  - RUN: normal operation.
  - TRAPPED: entered on any fault; left only by reset.

Test Plan:
- Reset, then push 4 type `i64 -> next cycle top_data=4, top_type=`i64, depth=1, empty=0, trap=0.
- Push 3 (`i32) then 5 (`i32); assert pop2+push with data 8 -> depth=1, top_data=8, second_data=0, trap=0.
- Pop on empty stack -> trap=9, depth=0. A subsequent push of 7 is ignored: depth stays 0 and trap stays 9.
- Fill all 16 entries with values 0..15 -> full=1, top_data=15. A 17th push gives trap=8, top_data=15. Separately, push+pop with 99 while full -> top=99, depth=16, trap=0.
- Push 1, 2; pulse reset low between clock edges -> depth=0, empty=1, trap=0 immediately, before the next edge.
- Push 2 then pop2 -> trap=9, top_data=2, depth=1 (no write, no pop).

Source files
------------

// File: rtl/operand_stack_pkg.sv
// Shared definitions for the operand stack: wasm type tags, trap codes, FSM states.
package operand_stack_pkg;

  localparam logic [1:0] TYPE_I32 = 2'd0;
  localparam logic [1:0] TYPE_I64 = 2'd1;
  localparam logic [1:0] TYPE_F32 = 2'd2;
  localparam logic [1:0] TYPE_F64 = 2'd3;

  localparam logic [3:0] TRAP_NONE       = 4'd0;
  localparam logic [3:0] STACK_OVERFLOW  = 4'd8;
  localparam logic [3:0] STACK_UNDERFLOW = 4'd9;

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_TRAPPED = 1'b1
  } stack_state_t;

endpackage

// File: rtl/operand_stack_mem.sv
// Entry storage: one write port, two combinational read ports (top and second).
// Contents are not reset; validity is tracked by the depth pointer in the parent.
module operand_stack_mem #(
  parameter int DEPTH_LOG = 4,
  parameter int WORD_W    = 66
) (
  input  logic                 clk,
  input  logic                 wr_en,
  input  logic [DEPTH_LOG-1:0] wr_addr,
  input  logic [WORD_W-1:0]    wr_word,
  input  logic [DEPTH_LOG-1:0] top_addr,
  input  logic [DEPTH_LOG-1:0] second_addr,
  output logic [WORD_W-1:0]    top_word,
  output logic [WORD_W-1:0]    second_word
);

  logic [WORD_W-1:0] mem [2**DEPTH_LOG];

  // Single write port, written only when the parent accepted a push.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_word;
  end

  assign top_word    = mem[top_addr];
  assign second_word = mem[second_addr];

endmodule

// File: rtl/operand_stack.sv
// Typed operand stack for the wasm execute stage.
// state   | meaning
// RUN     | normal push/pop decode, depth and storage update each cycle
// TRAPPED | a fault was recorded; state frozen until reset
module operand_stack
  import operand_stack_pkg::*;
#(
  parameter int DEPTH_LOG = 4,
  parameter int WIDTH     = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 push,
  input  logic                 pop,
  input  logic                 pop2,
  input  logic [WIDTH-1:0]     push_data,
  input  logic [1:0]           push_type,
  output logic [WIDTH-1:0]     top_data,
  output logic [1:0]           top_type,
  output logic [WIDTH-1:0]     second_data,
  output logic [1:0]           second_type,
  output logic [DEPTH_LOG:0]   depth,
  output logic                 empty,
  output logic                 full,
  output logic [3:0]           trap
);

  localparam int DW = DEPTH_LOG + 1;
  localparam logic [DEPTH_LOG:0] FULL_DEPTH = DW'(2 ** DEPTH_LOG);
  localparam logic [DEPTH_LOG:0] ONE        = DW'(1);
  localparam logic [DEPTH_LOG:0] TWO        = DW'(2);

  stack_state_t         state_q, state_d;
  logic [3:0]           trap_q, trap_d;
  logic [DEPTH_LOG:0]   depth_q, depth_d;
  logic [DEPTH_LOG:0]   n_pop;
  logic [DEPTH_LOG:0]   wr_slot, top_slot, second_slot;
  logic                 wr_en;
  logic [WIDTH+1:0]     top_word, second_word;

  assign n_pop       = pop2 ? TWO : (pop ? ONE : '0);
  assign wr_slot     = depth_q - n_pop;
  assign top_slot    = depth_q - ONE;
  assign second_slot = depth_q - TWO;
  assign full        = (depth_q == FULL_DEPTH);
  assign empty       = (depth_q == '0);
  assign depth       = depth_q;
  assign trap        = trap_q;

  // State, trap code and depth pointer registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_RUN;
      trap_q  <= TRAP_NONE;
      depth_q <= '0;
    end else begin
      state_q <= state_d;
      trap_q  <= trap_d;
      depth_q <= depth_d;
    end
  end

  // Decode the request; a fault traps without touching depth or storage.
  always_comb begin
    state_d = state_q;
    trap_d  = trap_q;
    depth_d = depth_q;
    wr_en   = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (n_pop > depth_q) begin
          state_d = ST_TRAPPED;
          trap_d  = STACK_UNDERFLOW;
        end else if (push && (n_pop == '0) && full) begin
          state_d = ST_TRAPPED;
          trap_d  = STACK_OVERFLOW;
        end else begin
          wr_en   = push;
          depth_d = depth_q - n_pop + DW'(push);
        end
      end
      ST_TRAPPED: begin
        state_d = ST_TRAPPED;
      end
    endcase
  end

  operand_stack_mem #(
    .DEPTH_LOG (DEPTH_LOG),
    .WORD_W    (WIDTH + 2)
  ) u_mem (
    .clk         (clk),
    .wr_en       (wr_en),
    .wr_addr     (wr_slot[DEPTH_LOG-1:0]),
    .wr_word     ({push_type, push_data}),
    .top_addr    (top_slot[DEPTH_LOG-1:0]),
    .second_addr (second_slot[DEPTH_LOG-1:0]),
    .top_word    (top_word),
    .second_word (second_word)
  );

  // Invalid entries read as zero data with type zero.
  always_comb begin
    top_data    = '0;
    top_type    = '0;
    second_data = '0;
    second_type = '0;
    if (depth_q >= ONE) begin
      top_data = top_word[WIDTH-1:0];
      top_type = top_word[WIDTH+1:WIDTH];
    end
    if (depth_q >= TWO) begin
      second_data = second_word[WIDTH-1:0];
      second_type = second_word[WIDTH+1:WIDTH];
    end
  end

endmodule

// File: tb/tb_operand_stack.sv
// Directed plan steps plus randomized traffic against a queue-based stack model.
module tb_operand_stack;
  import operand_stack_pkg::*;

  typedef struct {
    logic [63:0] data;
    logic [1:0]  typ;
  } entry_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        push = 1'b0, pop = 1'b0, pop2 = 1'b0;
  logic [63:0] push_data = '0;
  logic [1:0]  push_type = '0;
  logic [63:0] top_data, second_data;
  logic [1:0]  top_type, second_type;
  logic [4:0]  depth;
  logic        empty, full;
  logic [3:0]  trap;

  entry_t      model_q[$];
  int          model_trap = 0;
  int          checks = 0;
  int          failures = 0;

  operand_stack #(.DEPTH_LOG(4), .WIDTH(64)) dut (
    .clk(clk), .reset(reset), .push(push), .pop(pop), .pop2(pop2),
    .push_data(push_data), .push_type(push_type),
    .top_data(top_data), .top_type(top_type),
    .second_data(second_data), .second_type(second_type),
    .depth(depth), .empty(empty), .full(full), .trap(trap)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    int sz;
    sz = model_q.size();
    check({tag, ":depth"}, 64'(depth), 64'(sz));
    check({tag, ":empty"}, 64'(empty), 64'(sz == 0));
    check({tag, ":full"},  64'(full),  64'(sz == 16));
    check({tag, ":trap"},  64'(trap),  64'(model_trap));
    check({tag, ":top_data"},  top_data,  sz >= 1 ? model_q[sz-1].data : 64'd0);
    check({tag, ":top_type"},  64'(top_type),  64'(sz >= 1 ? model_q[sz-1].typ : 2'd0));
    check({tag, ":sec_data"},  second_data, sz >= 2 ? model_q[sz-2].data : 64'd0);
    check({tag, ":sec_type"},  64'(second_type), 64'(sz >= 2 ? model_q[sz-2].typ : 2'd0));
  endtask

  // Drive one cycle's request, advance the model, then compare after the edge.
  task automatic step(input string tag, input logic pu, input logic po, input logic po2,
                      input logic [63:0] d, input logic [1:0] t);
    int n;
    entry_t e;
    @(negedge clk);
    push = pu; pop = po; pop2 = po2; push_data = d; push_type = t;
    @(posedge clk);
    #1;
    n = po2 ? 2 : (po ? 1 : 0);
    if (model_trap == 0) begin
      if (n > model_q.size()) model_trap = 9;
      else if (pu && n == 0 && model_q.size() == 16) model_trap = 8;
      else begin
        repeat (n) void'(model_q.pop_back());
        if (pu) begin
          e.data = d; e.typ = t;
          model_q.push_back(e);
        end
      end
    end
    push = 1'b0; pop = 1'b0; pop2 = 1'b0;
    check_model(tag);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    reset = 1'b0;
    model_q.delete();
    model_trap = 0;
    #2;
    check_model(tag);
    reset = 1'b1;
  endtask

  initial begin
    int r;
    // Reset state
    #12;
    check_model("reset");
    reset = 1'b1;

    // Push 4 as i64
    step("push4", 1, 0, 0, 64'd4, TYPE_I64);
    check("push4_top_const", top_data, 64'd4);
    check("push4_type_const", 64'(top_type), 64'(TYPE_I64));

    // Binary op: pop2 + push result
    do_reset("rst_a");
    step("push3", 1, 0, 0, 64'd3, TYPE_I32);
    step("push5", 1, 0, 0, 64'd5, TYPE_I32);
    step("pop2push8", 1, 0, 1, 64'd8, TYPE_I32);
    check("pop2push8_depth_const", 64'(depth), 64'd1);
    check("pop2push8_top_const", top_data, 64'd8);

    // Underflow on empty, then frozen
    do_reset("rst_b");
    step("pop_empty", 0, 1, 0, 64'd0, TYPE_I32);
    check("underflow_trap_const", 64'(trap), 64'd9);
    step("push_after_trap", 1, 0, 0, 64'd7, TYPE_I32);
    check("frozen_depth_const", 64'(depth), 64'd0);

    // Fill to full, then overflow
    do_reset("rst_c");
    for (int i = 0; i < 16; i++) step("fill", 1, 0, 0, 64'(i), TYPE_I32);
    check("full_const", 64'(full), 64'd1);
    step("push17", 1, 0, 0, 64'd16, TYPE_I32);
    check("overflow_trap_const", 64'(trap), 64'd8);
    check("overflow_top_const", top_data, 64'd15);

    // Replace top while full is legal
    do_reset("rst_d");
    for (int i = 0; i < 16; i++) step("fill2", 1, 0, 0, 64'(i), TYPE_F64);
    step("replace_full", 1, 1, 0, 64'd99, TYPE_F32);
    check("replace_top_const", top_data, 64'd99);
    check("replace_depth_const", 64'(depth), 64'd16);

    // Asynchronous reset between edges
    do_reset("rst_e");
    step("push1", 1, 0, 0, 64'd1, TYPE_I32);
    step("push2", 1, 0, 0, 64'd2, TYPE_I32);
    reset = 1'b0;
    model_q.delete();
    model_trap = 0;
    #1;
    check_model("async_rst");
    check("async_empty_const", 64'(empty), 64'd1);
    #1;
    reset = 1'b1;

    // pop2 with one entry: underflow, no write, no pop
    do_reset("rst_f");
    step("push2b", 1, 0, 0, 64'd2, TYPE_I32);
    step("pop2_one", 0, 0, 1, 64'd0, TYPE_I32);
    check("pop2_one_trap_const", 64'(trap), 64'd9);
    check("pop2_one_top_const", top_data, 64'd2);

    // Randomized traffic
    for (int round = 0; round < 10; round++) begin
      do_reset("rst_rand");
      for (int k = 0; k < 40; k++) begin
        r = int'($urandom_range(0, 99));
        if (r < 40)      step("rnd_push", 1, 0, 0, {$urandom, $urandom}, 2'($urandom_range(0, 3)));
        else if (r < 55) step("rnd_pop", 0, 1, 0, 64'd0, 2'd0);
        else if (r < 62) step("rnd_pop2", 0, 0, 1, 64'd0, 2'd0);
        else if (r < 74) step("rnd_pushpop", 1, 1, 0, {$urandom, $urandom}, 2'($urandom_range(0, 3)));
        else if (r < 82) step("rnd_pushpop2", 1, 0, 1, {$urandom, $urandom}, 2'($urandom_range(0, 3)));
        else if (r < 86) step("rnd_popboth", 0, 1, 1, 64'd0, 2'd0);
        else             step("rnd_idle", 0, 0, 0, {$urandom, $urandom}, 2'd0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
